// File: rtl/aes_pkg.sv
`default_nettype none
// =============================================================================
// Module   : aes_pkg
// Brief    : Shared AES widths, FSM state type and GF(2^8) xtime helper.
// Revision : 1.0
// =============================================================================
package aes_pkg;

  localparam int BYTE      = 8;
  localparam int WORD      = 32;
  localparam int SENTENCE  = 128;
  localparam int COL_CNT_W = 2;

  localparam logic [BYTE-1:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
    return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? AES_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_mix_col_word.sv
`default_nettype none
// =============================================================================
// Module   : inv_mix_col_word
// Brief    : Combinational InvMixColumns transform of one 32-bit column.
// Revision : 1.0
// =============================================================================
module inv_mix_col_word
  import aes_pkg::*;
(
  input  logic [WORD-1:0] col,
  output logic [WORD-1:0] result
);

  logic [BYTE-1:0] w_b  [4];
  logic [BYTE-1:0] w_x2 [4];
  logic [BYTE-1:0] w_x4 [4];
  logic [BYTE-1:0] w_x8 [4];
  logic [BYTE-1:0] w_m9 [4];
  logic [BYTE-1:0] w_mb [4];
  logic [BYTE-1:0] w_md [4];
  logic [BYTE-1:0] w_me [4];

  // Row 0 lives in the top byte of the column.
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign w_b[i]  = col[WORD-1-BYTE*i -: BYTE];
    assign w_x2[i] = xtime(w_b[i]);
    assign w_x4[i] = xtime(w_x2[i]);
    assign w_x8[i] = xtime(w_x4[i]);
    assign w_m9[i] = w_x8[i] ^ w_b[i];
    assign w_mb[i] = w_x8[i] ^ w_x2[i] ^ w_b[i];
    assign w_md[i] = w_x8[i] ^ w_x4[i] ^ w_b[i];
    assign w_me[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
  end

  assign result = {w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3],
                   w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3],
                   w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3],
                   w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3]};

endmodule
`default_nettype wire

// File: rtl/inv_mix_columns_seq.sv
`default_nettype none
// =============================================================================
// Module   : inv_mix_columns_seq
// Brief    : Iterative InvMixColumns, one column per clock, valid/ready on both sides.
// Revision : 1.0
// =============================================================================
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SENTENCE-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SENTENCE-1:0] out_data,
  output logic                busy
);

  localparam logic [COL_CNT_W-1:0] c_last_col = COL_CNT_W'(3);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [COL_CNT_W-1:0]   r_cnt;
  logic [SENTENCE-1:0]    r_data;
  logic [SENTENCE-33:0]   r_result;
  logic [SENTENCE-1:0]    r_out_data;
  logic [WORD-1:0]        w_col;
  logic                   w_accept;

  inv_mix_col_word u_col (
    .col    (r_data[SENTENCE-1 -: WORD]),
    .result (w_col)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // in_ready in DONE follows out_ready combinationally so a new state can
  // be taken in the same cycle the previous result is handed off.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (r_cnt == c_last_col) w_state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready     = 1'b1;
          w_state_next = in_valid ? BUSY : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept = in_ready & in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_data     <= '0;
      r_result   <= '0;
      r_out_data <= '0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_cnt  <= '0;
    end else if (r_state == BUSY) begin
      r_data   <= {r_data[SENTENCE-WORD-1:0], {WORD{1'b0}}};
      r_result <= {r_result[SENTENCE-2*WORD-1:0], w_col};
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == c_last_col) r_out_data <= {r_result, w_col};
    end
  end

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_columns_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_inv_mix_columns_seq
// Brief    : Self-checking bench for inv_mix_columns_seq against a GF(2^8) matrix model.
// Revision : 1.0
// =============================================================================
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1B;
    end
    return p;
  endfunction

  // Circulant matrix product per column: r_i = sum_j m[(j-i) mod 4] * b_j.
  function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inverse);
    logic [7:0]   m [4];
    logic [7:0]   b [4];
    logic [7:0]   r;
    logic [127:0] o = '0;
    if (inverse) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) b[j] = s[127 - 32*c - 8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r = r ^ gmul(m[(j - i) & 3], b[j]);
        o[127 - 32*c - 8*i -: 8] = r;
      end
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for out_valid, sampling 1 time unit after each edge.
  task automatic wait_out(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int k = 0; k < 20; k++) begin
      if (!ok) begin
        @(posedge clk); #1;
        if (out_valid) begin ok = 1'b1; t = cyc; end
      end
    end
    check("out_valid_timeout", 128'(ok), 128'd1);
  endtask

  task automatic transfer(input logic [127:0] d, output logic [127:0] res, output int lat);
    int acc, t;
    bit ok;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0; in_data = 'x;
    wait_out(t, ok);
    lat = t - acc;
    res = out_data;
  endtask

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'h4d7ebdf8_d5d5d7d6_01010101_c6c6c6c6;
  localparam logic [127:0] E2 = 128'h2d26314c_d4d4d4d5_01010101_c6c6c6c6;

  initial begin
    logic [127:0] res, orig, junk;
    int lat, t1, t2;
    bit ok, seen;

    do_reset();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data",  out_data,        128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_busy",      128'(busy),      128'd0);

    // Standard vector and latency
    transfer(V1, res, lat);
    check("single_data", res, E1);
    check("single_model", res, mix_state(V1, 1'b1));
    check("single_latency", 128'(lat), 128'd4);

    // Backpressure: in_valid held high with junk while BUSY and stalled DONE
    do_reset();
    in_valid = 1'b1; in_data = V1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = rand128();
    check("bp_busy", 128'(busy), 128'd1);
    wait_out(t1, ok);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_hold_data",  out_data,         E1);
      check("bp_hold_valid", 128'(out_valid),  128'd1);
      check("bp_in_ready",   128'(in_ready),   128'd0);
      in_data = rand128();
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 check("bp_ready_comb", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    check("bp_after_valid", 128'(out_valid), 128'd0);
    check("bp_after_ready", 128'(in_ready),  128'd1);
    check("bp_after_busy",  128'(busy),      128'd0);

    // Back-to-back: second state offered while first is still computing
    do_reset();
    in_valid = 1'b1; in_data = V2; out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = E2;
    wait_out(t1, ok);
    check("b2b_first", out_data, E2);
    check("b2b_in_ready_done", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 'x;
    check("b2b_accept_busy", 128'(busy), 128'd1);
    wait_out(t2, ok);
    check("b2b_spacing", 128'(t2 - t1), 128'd5);
    check("b2b_second", out_data, mix_state(E2, 1'b1));

    // Reset mid-BUSY at counter=2
    do_reset();
    in_valid = 1'b1; in_data = rand128(); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy",     128'(busy),      128'd0);
    check("midrst_in_ready", 128'(in_ready),  128'd1);
    check("midrst_out_data", out_data,        128'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 128'(seen), 128'd0);
    junk = rand128();
    transfer(junk, res, lat);
    check("midrst_clean", res, mix_state(junk, 1'b1));

    // Round trip through forward MixColumns
    for (int n = 0; n < 1000; n++) begin
      orig = rand128();
      transfer(mix_state(orig, 1'b0), res, lat);
      check("roundtrip", res, orig);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Iterative AES InvMixColumns engine for the decryption datapath. It takes one 128-bit state, transforms one 32-bit column per clock through a shared inverse-column multiplier, and returns the full 128-bit result.
Valid/ready handshakes on both sides let it sit between InvShiftRows/InvSubBytes and AddRoundKey stages.
It is the inverse of the existing combinational forward MixColumns column function.

Parameters:
BYTE, 8, byte width
WORD, 32, column width (4 bytes)
SENTENCE, 128, state width (4 columns)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  SENTENCE  state; column 0 = [127:96], column 3 = [31:0]
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  SENTENCE  InvMixColumns(in_data), same column order
busy  output  1  high in BUSY state

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, column counter=0, data shift register=0. in_ready is combinational and reads 1 in IDLE after reset.
- Column byte order: within a column, the byte at [31:24] is row 0 (b0), down to [7:0] as row 3 (b3).
- Per-column equations in GF(2^8), polynomial 0x11B:
  - r0 = 0e·b0 ^ 0b·b1 ^ 0d·b2 ^ 09·b3
  - r1 = 09·b0 ^ 0e·b1 ^ 0b·b2 ^ 0d·b3
  - r2 = 0d·b0 ^ 09·b1 ^ 0e·b2 ^ 0b·b3
  - r3 = 0b·b0 ^ 0d·b1 ^ 09·b2 ^ 0e·b3
- Constants are built from xtime chains: x2, x4, x8. Then 09 = x8^x1, 0b = x8^x2^x1, 0d = x8^x4^x1, 0e = x8^x4^x2. All byte-wide; no width growth.
- State machine:
  - IDLE: in_ready=1. On in_valid, latch in_data into the data shift register, clear the counter, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, apply the column function to data[127:96]. Shift the result into the result register from the LSB side (result = {result[95:0], col}). Shift data left by WORD. Increment the counter. When the counter reaches 3, go to DONE with out_valid=1 and out_data=result on the next edge.
  - DONE: out_valid=1 and out_data is held stable until out_ready=1.
    - out_ready=1 and in_valid=0: go to IDLE, out_valid=0.
    - out_ready=1 and in_valid=1: back-to-back. Accept the new state in the same cycle, go to BUSY, out_valid=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready to in_ready, and it is required.
- Latency: the accept edge is N, and out_valid is high from edge N+4. Throughput is one state per 5 cycles with out_ready held high and in_valid continuously asserted.
- in_valid during BUSY, or during DONE with out_ready=0, is not accepted; the upstream must hold the data.
- out_data is unchanged while out_valid=1 and out_ready=0.
- out_data keeps its last value after handoff; it is only meaningful when out_valid=1.
- rst asserted in any state has priority over the handshake. The partial result is discarded, all registers return to reset values, and no out_valid pulse is produced for the aborted state.
- X on in_data while in_valid=0 must not propagate into state or out_valid.

Decomposition:
- aes_pkg:
  - BYTE, WORD, SENTENCE
  - AES_POLY = 8'h1B
  - state enum {IDLE, BUSY, DONE}
  - COL_CNT_W = 2
  - xtime function
- Sub-module inv_mix_col_word: combinational WORD→WORD implementing the four equations above, instantiated once in the top.
- Top: FSM, counter, data and result shift registers, handshake logic.

Test Plan:
- Reset and idle: after rst → out_valid=0, out_data=0, in_ready=1, busy=0.
- Single state with a standard check:
  - Input: in_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 accepted at edge N.
  - Required: out_valid rises at edge N+4 with out_data = db135345_f20a225c_01010101_c6c6c6c6.
- Backpressure: same input with out_ready=0 for 6 cycles → out_data stable, in_ready=0, in_valid ignored. Then out_ready=1 → one-cycle handoff and return to IDLE.
- Back-to-back:
  - First state: 4d7ebdf8_d5d5d7d6_01010101_c6c6c6c6.
  - Second state: its expected result from the first transfer, presented with in_valid held high and out_ready=1.
  - Required: first out_data = 2d26314c_d4d4d4d5_01010101_c6c6c6c6. The second state is accepted in the DONE cycle, and outputs are 5 cycles apart.
- Reset mid-BUSY: assert rst at counter=2 → next cycle IDLE, out_valid stays 0. A subsequent clean transfer yields the correct result.
- Round-trip: random 128-bit values are passed through the existing forward MixColumns (per column) and then this block → out_data equals the original input, for ≥1000 vectors.
